// File: rtl/conv2d_pkg.sv
// rtl/conv2d_pkg.sv - shared state encoding, padding modes and helpers for the window generator
package conv2d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam logic PAD_ZERO = 1'b0;
  localparam logic PAD_REPL = 1'b1;

  function automatic int clog2(input int value);
    int v;
    int n;
    v = value - 1;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/conv2d_window_gen_if.sv
// rtl/conv2d_window_gen_if.sv - frame memory read port and tap stream between generator and consumer
interface conv2d_window_gen_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] tap_data;
  logic              tap_valid;
  logic              tap_ready;
  logic              tap_last;

  modport master (
    output rd_en, rd_addr, tap_data, tap_valid, tap_last,
    input  rd_data, tap_ready
  );

  modport slave (
    input  rd_en, rd_addr, tap_data, tap_valid, tap_last,
    output rd_data, tap_ready
  );

endinterface

// File: rtl/conv2d_tap_fifo.sv
// rtl/conv2d_tap_fifo.sv - small output FIFO holding {tap data, last} entries
module conv2d_tap_fifo
  import conv2d_pkg::*;
#(
  parameter int W     = 13,
  parameter int DEPTH = 2,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/conv2d_window_gen.sv
// rtl/conv2d_window_gen.sv - streams every KxK neighbourhood of a runtime-sized frame, one tap per cycle
module conv2d_window_gen
  import conv2d_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12,
  parameter int DIM_W  = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DIM_W-1:0]   img_rows,
  input  logic [DIM_W-1:0]   img_cols,
  input  logic               pad_mode,
  output logic               busy,
  output logic               done,
  conv2d_window_gen_if.master bus
);

  localparam int R          = (K - 1) / 2;
  localparam int CW         = DIM_W + 2;
  localparam int PW         = 2 * DIM_W;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = clog2(FIFO_DEPTH + 1);

  typedef logic signed [CW-1:0] coord_t;

  localparam coord_t         R_POS = coord_t'(R);
  localparam coord_t         R_NEG = -R_POS;
  localparam logic [DIM_W:0] STEP  = (DIM_W + 1)'(STRIDE);

  state_t           state;
  logic [DIM_W-1:0] rows_q;
  logic [DIM_W-1:0] cols_q;
  logic             pad_q;
  logic [DIM_W:0]   r;
  logic [DIM_W:0]   c;
  coord_t           dr;
  coord_t           dc;

  // One-deep tag pipe matching the memory's read latency.
  logic pipe_valid;
  logic pipe_zero;
  logic pipe_last;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W:0]   fifo_din;
  logic [DATA_W:0]   fifo_dout;
  logic [DATA_W-1:0] push_data;
  logic              unused_fifo_full;
  logic [CNT_W:0]    credit;

  coord_t           row;
  coord_t           col;
  coord_t           rows_s;
  coord_t           cols_s;
  logic             row_lo;
  logic             row_hi;
  logic             col_lo;
  logic             col_hi;
  logic             oob;
  logic             zero_tap;
  logic [DIM_W-1:0] row_eff;
  logic [DIM_W-1:0] col_eff;
  logic [PW-1:0]    row_mul;
  logic [PW:0]      addr_full;
  logic             issue;
  logic             tap_last_now;
  logic             c_wrap;
  logic             r_wrap;
  logic             frame_end;
  logic             drain_ok;

  assign row    = $signed({1'b0, r}) + dr;
  assign col    = $signed({1'b0, c}) + dc;
  assign rows_s = $signed({2'b00, rows_q});
  assign cols_s = $signed({2'b00, cols_q});
  assign row_lo = row[CW-1];
  assign col_lo = col[CW-1];
  assign row_hi = (row >= rows_s);
  assign col_hi = (col >= cols_s);
  assign oob    = row_lo || row_hi || col_lo || col_hi;

  // Clamped coordinates only matter for replicate mode; zero-mode OOB taps never read.
  assign row_eff   = row_lo ? '0 : (row_hi ? rows_q - 1'b1 : row[DIM_W-1:0]);
  assign col_eff   = col_lo ? '0 : (col_hi ? cols_q - 1'b1 : col[DIM_W-1:0]);
  assign row_mul   = PW'(row_eff) * PW'(cols_q);
  assign addr_full = (PW + 1)'(row_mul) + (PW + 1)'(col_eff);
  assign zero_tap  = oob && (pad_q != PAD_REPL);

  assign tap_last_now = (dr == R_POS) && (dc == R_POS);
  assign c_wrap       = ((c + STEP) >= {1'b0, cols_q});
  assign r_wrap       = ((r + STEP) >= {1'b0, rows_q});
  assign frame_end    = tap_last_now && c_wrap && r_wrap;

  assign fifo_pop = !fifo_empty && bus.tap_ready;
  assign credit   = {1'b0, fifo_count} + (CNT_W + 1)'(pipe_valid);
  assign issue    = (state == ST_RUN) && ((credit < (CNT_W + 1)'(2)) || fifo_pop);
  assign drain_ok = !pipe_valid && (fifo_empty || ((fifo_count == CNT_W'(1)) && fifo_pop));

  assign bus.rd_en   = issue && !zero_tap;
  assign bus.rd_addr = bus.rd_en ? ADDR_W'(addr_full) : '0;

  assign fifo_push        = pipe_valid;
  assign push_data        = pipe_zero ? '0 : bus.rd_data;
  assign fifo_din         = {push_data, pipe_last};
  assign unused_fifo_full = fifo_full;

  assign bus.tap_valid = !fifo_empty;
  assign bus.tap_data  = fifo_empty ? '0 : fifo_dout[DATA_W:1];
  assign bus.tap_last  = !fifo_empty && fifo_dout[0];

  conv2d_tap_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      rows_q     <= '0;
      cols_q     <= '0;
      pad_q      <= PAD_ZERO;
      r          <= '0;
      c          <= '0;
      dr         <= '0;
      dc         <= '0;
      pipe_valid <= 1'b0;
      pipe_zero  <= 1'b0;
      pipe_last  <= 1'b0;
    end else begin
      done       <= 1'b0;
      pipe_valid <= issue;
      pipe_zero  <= issue && zero_tap;
      pipe_last  <= issue && tap_last_now;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rows_q <= img_rows;
            cols_q <= img_cols;
            pad_q  <= pad_mode;
            r      <= '0;
            c      <= '0;
            dr     <= R_NEG;
            dc     <= R_NEG;
            busy   <= 1'b1;
            state  <= (img_rows == '0 || img_cols == '0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          // Window taps are column-major: dr sweeps fastest, then dc, then centre.
          if (issue) begin
            if (frame_end) begin
              state <= ST_DRAIN;
            end else if (dr != R_POS) begin
              dr <= dr + coord_t'(1);
            end else begin
              dr <= R_NEG;
              if (dc != R_POS) begin
                dc <= dc + coord_t'(1);
              end else begin
                dc <= R_NEG;
                if (c_wrap) begin
                  c <= '0;
                  r <= r + STEP;
                end else begin
                  c <= c + STEP;
                end
              end
            end
          end
        end
        ST_DRAIN: begin
          if (drain_ok) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_window_gen.sv
// tb/tb_conv2d_window_gen.sv - scoreboard bench for conv2d_window_gen
module tb_conv2d_window_gen;
  import conv2d_pkg::*;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int DIM_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start0;
  logic             start1;
  logic             pad;
  logic             ready;
  logic             sel;
  logic             chk_en;
  logic             rand_rdy;
  logic [DIM_W-1:0] rows;
  logic [DIM_W-1:0] cols;
  logic             busy0, done0, busy1, done1;

  conv2d_window_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if0 ();
  conv2d_window_gen_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) if1 ();

  conv2d_window_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .K(3), .STRIDE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .img_rows(rows), .img_cols(cols),
    .pad_mode(pad), .busy(busy0), .done(done0), .bus(if0)
  );

  conv2d_window_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIM_W(DIM_W), .K(5), .STRIDE(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .img_rows(rows), .img_cols(cols),
    .pad_mode(pad), .busy(busy1), .done(done1), .bus(if1)
  );

  always #5 clk = ~clk;

  assign if0.tap_ready = ready;
  assign if1.tap_ready = ready;

  // Frame memory with one-cycle read latency, mem[a] = a.
  always @(posedge clk) begin
    if (if0.rd_en) if0.rd_data <= DATA_W'(if0.rd_addr);
    if (if1.rd_en) if1.rd_data <= DATA_W'(if1.rd_addr);
  end

  logic              m_valid, m_last, m_rd_en, m_busy, m_done;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W-1:0] m_addr;

  assign m_valid = sel ? if1.tap_valid : if0.tap_valid;
  assign m_last  = sel ? if1.tap_last  : if0.tap_last;
  assign m_data  = sel ? if1.tap_data  : if0.tap_data;
  assign m_rd_en = sel ? if1.rd_en     : if0.rd_en;
  assign m_addr  = sel ? if1.rd_addr   : if0.rd_addr;
  assign m_busy  = sel ? busy1 : busy0;
  assign m_done  = sel ? done1 : done0;

  logic [DATA_W:0]   exp_q[$];
  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [DATA_W:0]   got_q[$];
  logic [ADDR_W-1:0] got_rd_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int tap_cnt, rd_cnt, done_cnt, busy_cnt, last_cnt, last_hs_cyc, done_cyc;
  logic            prev_stall;
  logic [DATA_W:0] prev_tap;

  int w1[9] = '{0, 0, 0, 0, 0, 5, 0, 1, 6};
  int w2[9] = '{0, 0, 5, 0, 0, 5, 1, 1, 6};

  task automatic check(input string name, input longint act, input longint req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic model_frame(input int nr, input int nc, input int k, input int st, input bit repl);
    int rr;
    rr = (k - 1) / 2;
    for (int r = 0; r < nr; r += st)
      for (int c = 0; c < nc; c += st)
        for (int dc = -rr; dc <= rr; dc++)
          for (int dr = -rr; dr <= rr; dr++) begin
            int y, x, a;
            bit oob, lst;
            y = r + dr;
            x = c + dc;
            oob = (y < 0) || (y >= nr) || (x < 0) || (x >= nc);
            lst = (dr == rr) && (dc == rr);
            if (y < 0) y = 0;
            if (y >= nr) y = nr - 1;
            if (x < 0) x = 0;
            if (x >= nc) x = nc - 1;
            a = y * nc + x;
            if (oob && !repl) exp_q.push_back({DATA_W'(0), lst});
            else begin
              exp_q.push_back({DATA_W'(a), lst});
              exp_rd_q.push_back(ADDR_W'(a));
            end
          end
  endtask

  task automatic check_win(input string name, input bit use_rd, input int w[9]);
    logic [DATA_W:0] e;
    check({name, "_size"}, (use_rd ? got_rd_q.size() : got_q.size()) >= 9, 1);
    if ((use_rd ? got_rd_q.size() : got_q.size()) >= 9)
      for (int i = 0; i < 9; i++) begin
        if (use_rd) check(name, got_rd_q[i], w[i]);
        else begin
          e = got_q[i];
          check(name, e[DATA_W:1], w[i]);
        end
      end
  endtask

  initial begin
    ready = 1'b1;
    forever begin
      @(negedge clk);
      ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: samples just after the falling edge, i.e. the values the next rising edge sees.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (chk_en) begin
        if (m_rd_en) begin
          rd_cnt++;
          got_rd_q.push_back(m_addr);
          if (exp_rd_q.size() == 0) begin
            n_chk++;
            $display("FAIL rd_unexpected: got read of %0d, expected no read", m_addr);
          end else check("rd_addr", m_addr, exp_rd_q.pop_front());
        end
        if (prev_stall) check("stall_hold", {m_valid, m_data, m_last}, {1'b1, prev_tap});
        if (!sel && rand_rdy) check("credit_le2", longint'(u_dut0.credit <= 3'd2), 1);
        if (m_valid && ready) begin
          tap_cnt++;
          got_q.push_back({m_data, m_last});
          last_hs_cyc = cyc;
          if (m_last) last_cnt++;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL tap_unexpected: got tap %0d, expected no tap", m_data);
          end else check("tap", {m_data, m_last}, exp_q.pop_front());
        end
        prev_stall = m_valid && !ready;
        prev_tap   = {m_data, m_last};
        if (m_busy) busy_cnt++;
        if (m_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  task automatic run_frame(input bit s, input int nr, input int nc, input int k, input int st,
                           input bit repl, input bit rnd, input int exp_taps, input bit dbl);
    @(negedge clk);
    sel = s;
    rows = DIM_W'(nr);
    cols = DIM_W'(nc);
    pad = repl ? PAD_REPL : PAD_ZERO;
    rand_rdy = rnd;
    exp_q.delete(); exp_rd_q.delete(); got_q.delete(); got_rd_q.delete();
    tap_cnt = 0; rd_cnt = 0; done_cnt = 0; busy_cnt = 0; last_cnt = 0;
    prev_stall = 1'b0;
    model_frame(nr, nc, k, st, repl);
    if (s) start1 = 1'b1;
    else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      @(negedge clk);
      if (dbl && i == 10) begin start0 = 1'b1; rows = 8'd2; cols = 8'd2; end
      if (dbl && i == 11) begin start0 = 1'b0; rows = DIM_W'(nr); cols = DIM_W'(nc); end
    end
    rand_rdy = 1'b0;
    repeat (3) @(negedge clk);
    check("done_count", done_cnt, 1);
    check("tap_count", tap_cnt, exp_taps);
    check("exp_left", exp_q.size(), 0);
    check("rd_left", exp_rd_q.size(), 0);
    check("busy_after", m_busy, 0);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; rows = '0; cols = '0;
    pad = PAD_ZERO; sel = 1'b0; rand_rdy = 1'b0; chk_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_valid0", if0.tap_valid, 0);
    check("rst_rd_en0", if0.rd_en, 0);
    check("rst_valid1", if1.tap_valid, 0);
    check("rst_busy1", busy1, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_frame(0, 5, 5, 3, 1, 0, 0, 225, 0);
    check_win("t1_win00", 0, w1);
    check("t1_done_after_last", done_cyc - last_hs_cyc, 1);
    check("t1_last_count", last_cnt, 25);

    run_frame(0, 5, 5, 3, 1, 1, 0, 225, 0);
    check_win("t2_win00_addr", 1, w2);
    check("t2_rd_count", rd_cnt, 225);

    run_frame(0, 5, 5, 3, 1, 0, 1, 225, 0);
    check("t3_last_count", last_cnt, 25);

    run_frame(1, 4, 6, 5, 2, 0, 0, 150, 0);
    check("t4_last_count", last_cnt, 6);
    check("t4_size", got_q.size(), 150);
    if (got_q.size() > 137) begin
      logic [DATA_W:0] e;
      e = got_q[137];
      check("t4_centre_2_4", e[DATA_W:1], 16);
    end

    run_frame(0, 0, 5, 3, 1, 0, 0, 0, 0);
    check("t5_rows0_busy", busy_cnt, 1);

    run_frame(0, 1, 1, 3, 1, 0, 0, 9, 0);
    check("t5_1x1_reads", rd_cnt, 1);
    if (got_rd_q.size() > 0) check("t5_1x1_addr", got_rd_q[0], 0);

    @(negedge clk);
    chk_en = 1'b0;
    sel = 1'b0; rows = 8'd5; cols = 8'd5; pad = PAD_ZERO;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (20) @(negedge clk);
    check("t6_busy_mid", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_rd_en", if0.rd_en, 0);
    check("t6_rst_rd_addr", if0.rd_addr, 0);
    check("t6_rst_valid", if0.tap_valid, 0);
    check("t6_rst_data", if0.tap_data, 0);
    check("t6_rst_last", if0.tap_last, 0);
    check("t6_rst_busy", busy0, 0);
    check("t6_rst_done", done0, 0);
    rst = 1'b0;
    chk_en = 1'b1;

    run_frame(0, 5, 5, 3, 1, 0, 0, 225, 1);
    check("t6_dbl_last_count", last_cnt, 25);

    run_frame(0, 3, 4, 3, 1, 1, 0, 108, 0);
    check("t6_restart_reads", rd_cnt, 108);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
